// File: rtl/timer_1hz.sv
// Countdown timer with a DIVIDER-cycle prescaler producing a 1 Hz square wave and a one-cycle expiry pulse.
// Optional feature: define TIMER1HZ_BLINK_EN to make the indicator toggle once per second while counting.
module timer_1hz #(
    parameter int DIVIDER = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       startTimer,
    input  logic [3:0] value,
    output logic       clock1Hz,
    output logic       expired,
    output logic       indicator,
    output logic [3:0] counter,
    output logic [3:0] counter1Hz
);

    localparam logic [3:0] LAST = 4'(DIVIDER - 1);
    localparam logic [3:0] HALF = 4'(DIVIDER / 2);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_counter;
    logic [3:0] w_counterNext;
    logic [3:0] r_prescale;
    logic [3:0] w_prescaleNext;
    logic       r_expired;
    logic       w_expiredNext;
    logic       r_clock1Hz;
    logic       w_clock1HzNext;
    logic       r_indicator;
    logic       w_indicatorNext;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_counter   <= 4'd0;
            r_prescale  <= 4'd0;
            r_expired   <= 1'b0;
            r_clock1Hz  <= 1'b0;
            r_indicator <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_counter   <= w_counterNext;
            r_prescale  <= w_prescaleNext;
            r_expired   <= w_expiredNext;
            r_clock1Hz  <= w_clock1HzNext;
            r_indicator <= w_indicatorNext;
        end
    end

    // A start always wins over the countdown, so a restart swallows any expiry due that cycle.
    always_comb begin
        w_stateNext     = r_state;
        w_counterNext   = r_counter;
        w_prescaleNext  = r_prescale;
        w_expiredNext   = 1'b0;
        w_indicatorNext = r_indicator;

        if (startTimer) begin
            w_counterNext  = value;
            w_prescaleNext = 4'd0;
            if (value != 4'd0) begin
                w_stateNext     = ST_RUN;
                w_indicatorNext = 1'b1;
            end else begin
                w_stateNext   = ST_IDLE;
                w_expiredNext = 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            if (r_prescale < LAST) begin
                w_prescaleNext = r_prescale + 4'd1;
            end else begin
                w_prescaleNext = 4'd0;
`ifdef TIMER1HZ_BLINK_EN
                w_indicatorNext = ~r_indicator;
`endif
                if (r_counter <= 4'd1) begin
                    w_counterNext = 4'd0;
                    w_stateNext   = ST_IDLE;
                    w_expiredNext = 1'b1;
                end else begin
                    w_counterNext = r_counter - 4'd1;
                end
            end
        end else begin
            w_prescaleNext = 4'd0;
        end

`ifdef TIMER1HZ_BLINK_EN
        if (w_stateNext != ST_RUN) begin
            w_indicatorNext = 1'b0;
        end
`else
        w_indicatorNext = (w_stateNext == ST_RUN);
`endif

        // Registered from next-state values so the square wave lines up with counter1Hz.
        w_clock1HzNext = (w_stateNext == ST_RUN) && (w_prescaleNext >= HALF);
    end

    assign clock1Hz   = r_clock1Hz;
    assign expired    = r_expired;
    assign indicator  = r_indicator;
    assign counter    = r_counter;
    assign counter1Hz = r_prescale;

endmodule

// File: tb/tb_timer_1hz.sv
// Self-checking bench for timer_1hz: directed scenarios with literal expectations plus a randomized run
// checked every cycle against an elapsed-time model of the countdown.
module tb_timer_1hz;

    localparam int DIV = 16;

    logic       clock;
    logic       resetN;
    logic       startTimer;
    logic [3:0] value;
    logic       clock1Hz;
    logic       expired;
    logic       indicator;
    logic [3:0] counter;
    logic [3:0] counter1Hz;

    int errors = 0;
    int checks = 0;
    logic checkEn = 1'b0;

    // Model state: a countdown is just "cycles elapsed since load" against the loaded length.
    logic       mRunning = 1'b0;
    logic       mExpired = 1'b0;
    logic [3:0] mLoaded  = 4'd0;
    int         mElapsed = 0;

    timer_1hz #(.DIVIDER(DIV)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .startTimer (startTimer),
        .value      (value),
        .clock1Hz   (clock1Hz),
        .expired    (expired),
        .indicator  (indicator),
        .counter    (counter),
        .counter1Hz (counter1Hz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] v);
        startTimer = s;
        value      = v;
        @(negedge clock);
    endtask

    always @(posedge clock or negedge resetN) begin : modelBlk
        int e;
        if (!resetN) begin
            mRunning <= 1'b0;
            mExpired <= 1'b0;
            mLoaded  <= 4'd0;
            mElapsed <= 0;
        end else if (startTimer) begin
            mLoaded  <= value;
            mElapsed <= 0;
            mRunning <= (value != 4'd0);
            mExpired <= (value == 4'd0);
        end else if (mRunning) begin
            e = mElapsed + 1;
            mElapsed <= e;
            if (e == int'(mLoaded) * DIV) begin
                mExpired <= 1'b1;
                mRunning <= 1'b0;
                mLoaded  <= 4'd0;
            end else begin
                mExpired <= 1'b0;
            end
        end else begin
            mExpired <= 1'b0;
        end
    end

    always @(negedge clock) begin : cmpBlk
        int eCnt;
        int ePre;
        int eClk;
        int eInd;
        if (checkEn) begin
            if (mRunning) begin
                eCnt = int'(mLoaded) - mElapsed / DIV;
                ePre = mElapsed % DIV;
                eClk = (ePre >= DIV / 2) ? 1 : 0;
`ifdef TIMER1HZ_BLINK_EN
                eInd = ((mElapsed / DIV) % 2 == 0) ? 1 : 0;
`else
                eInd = 1;
`endif
            end else begin
                eCnt = int'(mLoaded);
                ePre = 0;
                eClk = 0;
                eInd = 0;
            end
            checkOutput("m_counter", int'(counter), eCnt);
            checkOutput("m_counter1Hz", int'(counter1Hz), ePre);
            checkOutput("m_clock1Hz", int'(clock1Hz), eClk);
            checkOutput("m_indicator", int'(indicator), eInd);
            checkOutput("m_expired", int'(expired), int'(mExpired));
        end
    end

    initial begin
        int pulses;
        int pulseAt;
        startTimer = 1'b0;
        value      = 4'd0;
        resetN     = 1'b1;
        #1 resetN  = 1'b0;
        repeat (3) @(negedge clock);
        resetN  = 1'b1;
        checkEn = 1'b1;

        $display("[TB] idle after reset");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 4'd0);
            checkOutput("idle_counter", int'(counter), 0);
            checkOutput("idle_counter1Hz", int'(counter1Hz), 0);
            checkOutput("idle_expired", int'(expired), 0);
        end

        $display("[TB] zero-length start");
        applyStimulus(1'b1, 4'd0);
        checkOutput("v0_expired", int'(expired), 1);
        checkOutput("v0_indicator", int'(indicator), 0);
        applyStimulus(1'b0, 4'd0);
        checkOutput("v0_expired_after", int'(expired), 0);

        $display("[TB] one-second countdown");
        applyStimulus(1'b1, 4'd1);
        checkOutput("v1_counter_load", int'(counter), 1);
        checkOutput("v1_prescale_load", int'(counter1Hz), 0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 4'd5);
            checkOutput("v1_prescale", int'(counter1Hz), k % 16);
            checkOutput("v1_clock1Hz", int'(clock1Hz), (k >= 8 && k <= 15) ? 1 : 0);
            checkOutput("v1_expired", int'(expired), (k == 16) ? 1 : 0);
        end
        checkOutput("v1_counter_end", int'(counter), 0);

        $display("[TB] three-second countdown");
        applyStimulus(1'b1, 4'd3);
        pulses  = 0;
        pulseAt = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 4'd0);
            if (expired) begin
                pulses++;
                pulseAt = k;
            end
            if (k == 15) checkOutput("v3_cnt15", int'(counter), 3);
            if (k == 16) checkOutput("v3_cnt16", int'(counter), 2);
            if (k == 32) checkOutput("v3_cnt32", int'(counter), 1);
            if (k == 48) checkOutput("v3_cnt48", int'(counter), 0);
        end
        checkOutput("v3_pulses", pulses, 1);
        checkOutput("v3_pulseAt", pulseAt, 48);

        $display("[TB] restart mid-countdown");
        applyStimulus(1'b1, 4'd3);
        for (int k = 1; k < 20; k++) applyStimulus(1'b0, 4'd0);
        applyStimulus(1'b1, 4'd2);
        checkOutput("rs_counter_load", int'(counter), 2);
        pulses  = 0;
        pulseAt = 0;
        for (int k = 1; k <= 45; k++) begin
            applyStimulus(1'b0, 4'd0);
            if (expired) begin
                pulses++;
                pulseAt = k;
            end
        end
        checkOutput("rs_pulses", pulses, 1);
        checkOutput("rs_pulseAt", pulseAt, 32);

        $display("[TB] asynchronous reset mid-countdown");
        applyStimulus(1'b1, 4'd3);
        for (int k = 1; k < 20; k++) applyStimulus(1'b0, 4'd0);
        checkOutput("ar_counter_before", int'(counter), 2);
        #2 resetN = 1'b0;
        #1;
        checkOutput("ar_counter", int'(counter), 0);
        checkOutput("ar_counter1Hz", int'(counter1Hz), 0);
        checkOutput("ar_clock1Hz", int'(clock1Hz), 0);
        checkOutput("ar_indicator", int'(indicator), 0);
        checkOutput("ar_expired", int'(expired), 0);
        repeat (3) applyStimulus(1'b0, 4'd0);
        resetN = 1'b1;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'b0, 4'd0);
            if (expired) pulses++;
        end
        checkOutput("ar_pulses", pulses, 0);
        checkOutput("ar_counter_idle", int'(counter), 0);

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            if (!resetN) begin
                resetN = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                resetN = 1'b0;
            end
            applyStimulus(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
        end

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
